// File: rtl/ffd_pipe.sv
// ffd_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready handshake,
// global enable, synchronous flush and bubble collapsing.
// Optional macro FFD_PIPE_OCC_EN adds an occ port holding the registered count of valid stages.
module ffd_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FFD_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH:0] rdy;
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [DEPTH-1:0] up_vld;

    // ready ripples back from the output; each stage sees its upstream neighbour
    always_comb begin
        rdy = '0;
        up_vld = '0;
        up_data = '{default: '0};
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) rdy[i] = ~vld_q[i] | rdy[i+1];
        up_data[0] = in_data;
        up_vld[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            up_data[i] = data_q[i-1];
            up_vld[i] = vld_q[i-1];
        end
    end

    assign in_ready = ena & ~flush & rdy[0];
    assign out_valid = ena & vld_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];

    // stage registers: flush drops valids but keeps data; only ready stages load
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
        end else if (flush) begin
            vld_q <= '0;
        end else if (ena) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    data_q[i] <= up_data[i];
                    vld_q[i] <= up_vld[i];
                end
            end
        end
    end

`ifdef FFD_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);
    logic in_xfer;
    logic out_xfer;
    assign in_xfer = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // occupancy: +1 on push only, -1 on pop only, cleared with the valids
    always_ff @(posedge clk) begin
        if (rst | flush) occ <= '0;
        else if (in_xfer & ~out_xfer) occ <= occ + OW'(1);
        else if (out_xfer & ~in_xfer) occ <= occ - OW'(1);
    end

    occ_matches_valids: assert property (@(posedge clk) disable iff (rst) occ == OW'($countones(vld_q)));
`endif
endmodule

// File: tb/tb_ffd_pipe.sv
// tb_ffd_pipe: vector table, directed sequences and random traffic against a queue model of ffd_pipe
module tb_ffd_pipe;
    localparam int D = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic clk = 1'b0;
    logic rst, ena, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
`ifdef FFD_PIPE_OCC_EN
    logic [1:0] occ;
`endif

    ffd_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .flush(flush),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef FFD_PIPE_OCC_EN
        ,
        .occ(occ)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit model_ok = 1'b0;

    // model: ordered items (oldest first), each with its stage position
    typedef struct {
        logic [7:0] d;
        int p;
    } item_t;
    item_t q[$];

    logic obs_ir, obs_ov;
    logic [7:0] obs_od;

    typedef struct {
        logic fl, iv, orr;
        logic [7:0] d;
        logic ir, ov;
        logic [7:0] od;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(logic fl, logic iv, logic orr, logic [7:0] d, logic ir, logic ov, logic [7:0] od);
        vec_t v;
        v.fl = fl; v.iv = iv; v.orr = orr; v.d = d; v.ir = ir; v.ov = ov; v.od = od;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // drive one cycle's inputs, compare against the model before the edge, advance model after it
    task automatic step(input logic r, input logic e, input logic f, input logic v,
                        input logic [7:0] d, input logic o);
        bit mv[8];
        bit slot0;
        logic eir, eov;
        int n;
        item_t it;
        rst = r; ena = e; flush = f; in_valid = v; in_data = d; out_ready = o;
        #1;
        n = q.size();
        for (int k = 0; k < n; k++)
            mv[k] = (k == 0) ? (q[0].p < D - 1 || o) : (q[k].p + 1 < q[k-1].p || mv[k-1]);
        slot0 = (n == 0) ? 1'b1 : (q[n-1].p > 0 || mv[n-1]);
        eir = e && !f && slot0;
        eov = e && n > 0 && q[0].p == D - 1;
        obs_ir = in_ready;
        obs_ov = out_valid;
        obs_od = out_data;
        if (model_ok) begin
            chk("model in_ready", in_ready, eir);
            chk("model out_valid", out_valid, eov);
            if (eov) chk("model out_data", out_data, q[0].d);
`ifdef FFD_PIPE_OCC_EN
            chk("model occ", occ, n);
`endif
        end
        @(posedge clk);
        if (r || f) q.delete();
        else if (e) begin
            for (int k = 0; k < n; k++) if (mv[k]) q[k].p = q[k].p + 1;
            if (n > 0 && q[0].p == D) void'(q.pop_front());
            if (v && eir) begin
                it.d = d;
                it.p = 0;
                q.push_back(it);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int idx, rcv;
        logic [7:0] frz_od;

        // reset: two cycles held, then released
        step(1, 1, 0, 0, 8'h00, 0);
        model_ok = 1'b1;
        step(1, 1, 0, 0, 8'h00, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        chk("reset out_valid", obs_ov, 1'b0);
        chk("reset out_data", obs_od, RV);
        chk("reset in_ready", obs_ir, 1'b1);

        // backpressure: 3 accepted, 04 held, then drain in order
        vt.push_back(mk(0, 1, 0, 8'h01, 1, 0, 8'h00));
        vt.push_back(mk(0, 1, 0, 8'h02, 1, 0, 8'h00));
        vt.push_back(mk(0, 1, 0, 8'h03, 1, 0, 8'h00));
        vt.push_back(mk(0, 1, 0, 8'h04, 0, 1, 8'h01));
        vt.push_back(mk(0, 1, 0, 8'h04, 0, 1, 8'h01));
        vt.push_back(mk(0, 1, 1, 8'h04, 1, 1, 8'h01));
        vt.push_back(mk(0, 1, 1, 8'h05, 1, 1, 8'h02));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 1, 8'h03));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 1, 8'h04));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 1, 8'h05));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 0, 8'h00));
        // flush with 3 in flight: 77 refused during flush, then passes through alone
        vt.push_back(mk(0, 1, 0, 8'hAA, 1, 0, 8'h00));
        vt.push_back(mk(0, 1, 0, 8'hBB, 1, 0, 8'h00));
        vt.push_back(mk(0, 1, 0, 8'hCC, 1, 0, 8'h00));
        vt.push_back(mk(1, 1, 0, 8'h77, 0, 1, 8'hAA));
        vt.push_back(mk(0, 1, 1, 8'h77, 1, 0, 8'h00));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 0, 8'h00));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 0, 8'h00));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 1, 8'h77));
        vt.push_back(mk(0, 0, 1, 8'h00, 1, 0, 8'h00));
        for (int i = 0; i < vt.size(); i++) begin
            step(0, 1, vt[i].fl, vt[i].iv, vt[i].d, vt[i].orr);
            chk($sformatf("vec%0d in_ready", i), obs_ir, vt[i].ir);
            chk($sformatf("vec%0d out_valid", i), obs_ov, vt[i].ov);
            if (vt[i].ov) chk($sformatf("vec%0d out_data", i), obs_od, vt[i].od);
        end

        // streaming 01..0A at full throughput, latency 3
        for (int k = 0; k < 14; k++) begin
            step(0, 1, 0, k < 10, 8'(k + 1), 1);
            if (k < 10) chk($sformatf("stream%0d in_ready", k), obs_ir, 1'b1);
            chk($sformatf("stream%0d out_valid", k), obs_ov, k >= 3 && k < 13);
            if (k >= 3 && k < 13) chk($sformatf("stream%0d out_data", k), obs_od, 8'(k - 2));
        end

        // enable freeze for 4 cycles mid-stream
        idx = 0;
        rcv = 0;
        frz_od = '0;
        for (int c = 0; c < 24; c++) begin
            automatic logic e = !(c >= 4 && c < 8);
            step(0, e, 0, idx < 8, 8'(8'h11 + idx), 1);
            if (!e) begin
                chk($sformatf("freeze%0d in_ready", c), obs_ir, 1'b0);
                chk($sformatf("freeze%0d out_valid", c), obs_ov, 1'b0);
                if (c == 4) frz_od = obs_od;
                else chk($sformatf("freeze%0d out_data held", c), obs_od, frz_od);
            end
            if (e && idx < 8 && obs_ir) idx++;
            if (obs_ov) begin
                chk($sformatf("freeze item%0d", rcv), obs_od, 8'(8'h11 + rcv));
                rcv++;
            end
        end
        chk("freeze accepted", idx, 8);
        chk("freeze delivered", rcv, 8);

`ifdef FFD_PIPE_OCC_EN
        // occupancy: fill, push+pop, flush
        step(0, 1, 0, 1, 8'h31, 0); chk("occ fill1", occ, 1);
        step(0, 1, 0, 1, 8'h32, 0); chk("occ fill2", occ, 2);
        step(0, 1, 0, 1, 8'h33, 0); chk("occ fill3", occ, 3);
        step(0, 1, 0, 1, 8'h34, 1); chk("occ push_pop", occ, 3);
        step(0, 1, 1, 1, 8'h35, 0); chk("occ flush", occ, 0);
`endif

        // random traffic incl. occasional reset, flush and freeze
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
